dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Single-port data-memory responder: accepts one read/write request at a time,
// inserts WAIT_CYCLES wait states, then issues a registered one-cycle mem_resp.
module dmem_responder #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned DEPTH_LOG2  = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_byte_enable,
    output logic [31:0] mem_rdata,
    output logic        mem_resp
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned IDX_W = DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;

    logic [IDX_W-1:0]   addr_q;
    logic [31:0]        wdata_q;
    logic [3:0]         be_q;
    logic               is_write_q;

    logic               accept_c;
    logic               load_c;
    logic               commit_c;
    logic [IDX_W-1:0]   rd_index_c;
    logic [31:0]        wmask_c;
    logic [31:0]        merged_c;
    logic               unused_c;

    logic [31:0]        mem_q [DEPTH];

    // Address bits outside the word index are deliberately ignored (wrap).
    assign unused_c = ^{mem_address[31:DEPTH_LOG2+2], mem_address[1:0]};

    // State and wait counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; acceptance is blocked while the previous mem_resp is
    // still high so a held request is never taken twice.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept_c   = 1'b0;
        load_c     = 1'b0;
        commit_c   = 1'b0;
        rd_index_c = addr_q;
        case (state_q)
            IDLE: begin
                if ((mem_read || mem_write) && !mem_resp) begin
                    accept_c   = 1'b1;
                    cnt_d      = CNT_W'(WAIT_CYCLES);
                    rd_index_c = mem_address[DEPTH_LOG2+1:2];
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                        load_c  = !mem_write;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = RESP;
                    load_c  = !is_write_q;
                end
            end
            RESP: begin
                state_d  = IDLE;
                commit_c = is_write_q;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Request capture at acceptance; write wins over a simultaneous read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            is_write_q <= 1'b0;
        end else if (accept_c) begin
            addr_q     <= mem_address[DEPTH_LOG2+1:2];
            wdata_q    <= mem_wdata;
            be_q       <= mem_byte_enable;
            is_write_q <= mem_write;
        end
    end

    // Byte-lane merge of the latched write data into the addressed word.
    always_comb begin
        wmask_c  = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
        merged_c = (mem_q[addr_q] & ~wmask_c) | (wdata_q & wmask_c);
    end

    // Storage words; a write commits on the edge that ends RESP.
    for (genvar g = 0; g < DEPTH; g++) begin : g_word
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                mem_q[g] <= '0;
            end else if (commit_c && (addr_q == IDX_W'(g))) begin
                mem_q[g] <= merged_c;
            end
        end
    end

    // Read data loads on the edge entering RESP and holds until the next read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_rdata <= '0;
        end else if (load_c) begin
            mem_rdata <= mem_q[rd_index_c];
        end
    end

    // Completion pulse, one cycle, registered from the RESP state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_resp <= 1'b0;
        end else begin
            mem_resp <= (state_q == RESP);
        end
    end

endmodule
